// File: rtl/prach_pkg.sv
// Shared PRACH constants and types.
//   NumChannel     : TDM slots per frame
//   NumChannelUsed : active channels (0..NumChannelUsed-1)
//   SampleW/ChnW   : sample and channel-index widths
//   pd_side_t      : sideband bundle carried alongside the polyphase pair
package prach_pkg;

  localparam int unsigned NumChannel     = 32;
  localparam int unsigned NumChannelUsed = 24;
  localparam int unsigned SampleW        = 16;
  localparam int unsigned ChnW           = 8;
  localparam int unsigned AddrW          = $clog2(NumChannel);

  typedef struct packed {
    logic            sync;
    logic            dv;
    logic [ChnW-1:0] chn;
  } pd_side_t;

  // Next expected channel, wrapping after the last used channel.
  function automatic logic [ChnW-1:0] next_chn(input logic [ChnW-1:0] chn);
    return (chn == ChnW'(NumChannelUsed - 1)) ? '0 : chn + ChnW'(1);
  endfunction

endpackage

// File: rtl/delay.sv
// Generic fixed-depth register pipeline with async active-low reset.
//   clk, rst_n : clock / reset
//   din        : Width-bit input
//   dout       : din delayed by Depth cycles (Depth >= 1)
module delay #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  logic [Width-1:0] pipe [Depth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Depth); i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < int'(Depth); i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[Depth-1];

endmodule

// File: rtl/prach_hb2_pd_ram.sv
// Simple-dual-port sample buffer, NumChannelUsed x SampleW, registered read.
//   we/waddr/wdata : write port
//   re/raddr       : read request; rdata valid the cycle after re
// Memory contents are not reset; only the read register is.
module prach_hb2_pd_ram
  import prach_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [AddrW-1:0]          waddr,
  input  logic signed [SampleW-1:0] wdata,
  input  logic                      re,
  input  logic [AddrW-1:0]          raddr,
  output logic signed [SampleW-1:0] rdata
);

  logic [SampleW-1:0] mem [NumChannelUsed];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; holds its value between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/prach_hb2_pd.sv
// Polyphase decomposer ahead of the PRACH half-band decimator.
// Even-phase samples are buffered per channel; each odd-phase sample is
// emitted together with the buffered even sample of the same channel.
//   din_dq/din_dv/din_chn/sync_in : TDM input stream
//   dout_dp1 : even-phase (older) sample, dout_dp2 : odd-phase (newer) sample
//   dout_dv/dout_chn/sync_out     : pair sideband, 2 cycles after input
//   err_seq  : sticky channel-sequence error, cleared by an accepted sync
module prach_hb2_pd
  import prach_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [SampleW-1:0] din_dq,
  input  logic                      din_dv,
  input  logic [ChnW-1:0]           din_chn,
  input  logic                      sync_in,
  output logic signed [SampleW-1:0] dout_dp1,
  output logic signed [SampleW-1:0] dout_dp2,
  output logic                      dout_dv,
  output logic [ChnW-1:0]           dout_chn,
  output logic                      sync_out,
  output logic                      err_seq
);

  localparam logic PhEven = 1'b0;
  localparam logic PhOdd  = 1'b1;

  logic            phase, phase_d;
  logic [ChnW-1:0] exp_chn, exp_chn_d;
  logic            err_d;
  logic            sync_pend, sync_pend_d;

  logic in_range_c, accept_c, sync_acc_c, odd_c, wr_c, first_pair_c;
  pd_side_t side_c, side_q;

  logic signed [SampleW-1:0] s1_dq;
  logic signed [SampleW-1:0] ram_rdata;

  // Input qualification: a sync always forces the sample into even phase.
  assign in_range_c   = din_chn < ChnW'(NumChannelUsed);
  assign accept_c     = din_dv & in_range_c;
  assign sync_acc_c   = accept_c & sync_in;
  assign odd_c        = accept_c & ~sync_in & (phase == PhOdd);
  assign wr_c         = accept_c & (sync_in | (phase == PhEven));
  assign first_pair_c = odd_c & (din_chn == '0) & sync_pend;

  // TDM position tracking and error flag.
  always_comb begin
    phase_d     = phase;
    exp_chn_d   = exp_chn;
    err_d       = err_seq;
    sync_pend_d = sync_pend;
    if (din_dv && !in_range_c) begin
      err_d = 1'b1;
    end else if (sync_acc_c) begin
      phase_d     = PhEven;
      exp_chn_d   = ChnW'(1);
      err_d       = (din_chn != '0);
      sync_pend_d = 1'b1;
    end else if (accept_c) begin
      if (din_chn != exp_chn) err_d = 1'b1;
      exp_chn_d = next_chn(din_chn);
      if (din_chn == ChnW'(NumChannelUsed - 1)) phase_d = ~phase;
      if (first_pair_c) sync_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= PhEven;
      exp_chn   <= '0;
      err_seq   <= 1'b0;
      sync_pend <= 1'b0;
    end else begin
      phase     <= phase_d;
      exp_chn   <= exp_chn_d;
      err_seq   <= err_d;
      sync_pend <= sync_pend_d;
    end
  end

  // A bare sync (no valid) passes straight through to sync_out.
  always_comb begin
    side_c      = '0;
    side_c.dv   = odd_c;
    side_c.chn  = din_chn;
    side_c.sync = (sync_in & ~din_dv) | first_pair_c;
  end

  delay #(
    .Width ($bits(pd_side_t)),
    .Depth (2)
  ) u_side_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (side_c),
    .dout  (side_q)
  );

  assign dout_dv  = side_q.dv;
  assign dout_chn = side_q.chn;
  assign sync_out = side_q.sync;

  prach_hb2_pd_ram u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_c),
    .waddr (AddrW'(din_chn)),
    .wdata (din_dq),
    .re    (odd_c),
    .raddr (AddrW'(din_chn)),
    .rdata (ram_rdata)
  );

  // Data path: stage 1 holds the odd sample while the buffer read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_dq    <= '0;
      dout_dp1 <= '0;
      dout_dp2 <= '0;
    end else begin
      if (accept_c) s1_dq <= din_dq;
      dout_dp1 <= ram_rdata;
      dout_dp2 <= s1_dq;
    end
  end

endmodule

// File: tb/tb_prach_hb2_pd.sv
// Self-checking bench for prach_hb2_pd: randomized TDM stimulus against a
// sample-level reference model of the decomposer.
module tb_prach_hb2_pd;

  localparam int USED = 24;

  logic               clk;
  logic               rst_n;
  logic signed [15:0] din_dq;
  logic               din_dv;
  logic [7:0]         din_chn;
  logic               sync_in;
  logic signed [15:0] dout_dp1;
  logic signed [15:0] dout_dp2;
  logic               dout_dv;
  logic [7:0]         dout_chn;
  logic               sync_out;
  logic               err_seq;

  prach_hb2_pd dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_dq   (din_dq),
    .din_dv   (din_dv),
    .din_chn  (din_chn),
    .sync_in  (sync_in),
    .dout_dp1 (dout_dp1),
    .dout_dp2 (dout_dp2),
    .dout_dv  (dout_dv),
    .dout_chn (dout_chn),
    .sync_out (sync_out),
    .err_seq  (err_seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit dv;
    bit sync;
    int chn;
    int dp1;
    int dp2;
  } exp_t;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state.
  bit   m_phase;
  int   m_exp;
  bit   m_err;
  bit   m_pend;
  int   m_buf [USED];
  exp_t pend_e;

  int out_cnt, sync_cnt;
  bit ramp_mode, ramp_data;
  int ramp_k, ramp_idx;

  task automatic chk(input string tag, input int obs, input int expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic int rand16();
    logic signed [15:0] r;
    r = 16'($urandom);
    return int'(r);
  endfunction

  // Apply one input sample to the model; returns the pair it produces.
  task automatic model_step(input bit dv, input int chn, input int dq, input bit sync,
                            output exp_t e);
    bit cur;
    e = '{dv: 0, sync: 0, chn: 0, dp1: 0, dp2: 0};
    if (sync && !dv) e.sync = 1;
    if (dv) begin
      if (chn >= USED) begin
        m_err = 1;
      end else if (sync) begin
        m_err      = (chn != 0);
        m_phase    = 0;
        m_exp      = 1;
        m_pend     = 1;
        m_buf[chn] = dq;
      end else begin
        if (chn != m_exp) m_err = 1;
        cur   = m_phase;
        m_exp = (chn + 1) % USED;
        if (chn == USED - 1) m_phase = ~m_phase;
        if (!cur) begin
          m_buf[chn] = dq;
        end else begin
          e.dv  = 1;
          e.chn = chn;
          e.dp1 = m_buf[chn];
          e.dp2 = dq;
          if (chn == 0 && m_pend) begin
            e.sync = 1;
            m_pend = 0;
          end
        end
      end
    end
  endtask

  task automatic check_out(input exp_t e);
    int f, c;
    chk("dout_dv", int'(dout_dv), int'(e.dv));
    chk("sync_out", int'(sync_out), int'(e.sync));
    if (e.dv) begin
      chk("dout_chn", int'(dout_chn), e.chn);
      chk("dout_dp1", int'(dout_dp1), e.dp1);
      chk("dout_dp2", int'(dout_dp2), e.dp2);
    end
    if (dout_dv) out_cnt++;
    if (sync_out) sync_cnt++;
    if (ramp_mode && dout_dv) begin
      f = ramp_idx / USED;
      c = ramp_idx % USED;
      chk("ramp_chn", int'(dout_chn), c);
      chk("ramp_dp1", int'(dout_dp1), 48 * f + c);
      chk("ramp_dp2", int'(dout_dp2), 48 * f + 24 + c);
      ramp_idx++;
    end
  endtask

  // One clock: drive, let the edge sample, then compare the previous pair.
  task automatic tick(input bit dv, input int chn, input int dq, input bit sync);
    exp_t e;
    din_dv  = dv;
    din_chn = 8'(chn);
    din_dq  = 16'(dq);
    sync_in = sync;
    @(posedge clk);
    #1;
    check_out(pend_e);
    model_step(dv, chn, dq, sync, e);
    chk("err_seq", int'(err_seq), int'(m_err));
    pend_e = e;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
  endtask

  task automatic send_chn(input int chn, input bit sync, input bit gaps);
    int dq;
    if (gaps) begin
      for (int g = 0; g < 6; g++) begin
        if ($urandom_range(0, 1) == 0) break;
        tick(0, 0, 0, 0);
      end
    end
    if (ramp_data) begin
      dq = ramp_k;
      ramp_k++;
    end else begin
      dq = rand16();
    end
    tick(1, chn, dq, sync);
  endtask

  task automatic send_range(input int lo, input int hi, input bit sync_first, input bit gaps);
    for (int c = lo; c <= hi; c++) send_chn(c, sync_first && (c == lo), gaps);
  endtask

  task automatic async_reset();
    #2;
    rst_n   = 1'b0;
    din_dv  = 1'b0;
    sync_in = 1'b0;
    #1;
    chk("arst_dv", int'(dout_dv), 0);
    chk("arst_sync", int'(sync_out), 0);
    chk("arst_chn", int'(dout_chn), 0);
    chk("arst_dp1", int'(dout_dp1), 0);
    chk("arst_dp2", int'(dout_dp2), 0);
    chk("arst_err", int'(err_seq), 0);
    m_phase = 0;
    m_exp   = 0;
    m_err   = 0;
    m_pend  = 0;
    pend_e  = '{dv: 0, sync: 0, chn: 0, dp1: 0, dp2: 0};
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_ramp(input bit gaps);
    ramp_data = 1;
    ramp_mode = 1;
    ramp_k    = 0;
    ramp_idx  = 0;
    out_cnt   = 0;
    sync_cnt  = 0;
    send_range(0, USED - 1, 1, gaps);
    for (int fr = 0; fr < 3; fr++) send_range(0, USED - 1, 0, gaps);
    idle(3);
    chk(gaps ? "gap_outs" : "ramp_outs", out_cnt, 48);
    chk(gaps ? "gap_syncs" : "ramp_syncs", sync_cnt, 1);
    ramp_mode = 0;
    ramp_data = 0;
  endtask

  initial begin
    rst_n   = 1'b0;
    din_dv  = 1'b0;
    din_chn = '0;
    din_dq  = '0;
    sync_in = 1'b0;
    m_phase = 0;
    m_exp   = 0;
    m_err   = 0;
    m_pend  = 0;
    pend_e  = '{dv: 0, sync: 0, chn: 0, dp1: 0, dp2: 0};
    for (int i = 0; i < USED; i++) m_buf[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dv", int'(dout_dv), 0);
    chk("rst_sync", int'(sync_out), 0);
    chk("rst_chn", int'(dout_chn), 0);
    chk("rst_dp1", int'(dout_dp1), 0);
    chk("rst_dp2", int'(dout_dp2), 0);
    chk("rst_err", int'(err_seq), 0);
    rst_n = 1'b1;

    // Sync + ramp, then the same with a 50% valid duty.
    run_ramp(0);
    run_ramp(1);

    // Skipped channel 6, then a sync at channel 0 clears the error.
    send_range(0, 5, 1, 0);
    send_range(7, USED - 1, 0, 0);
    idle(2);
    chk("skip_err", int'(err_seq), 1);
    send_range(0, USED - 1, 1, 0);
    chk("sync_clear", int'(err_seq), 0);
    out_cnt = 0;
    send_range(0, USED - 1, 0, 1);
    idle(2);
    chk("skip_odd_outs", out_cnt, USED);

    // Out-of-range channel inside an even frame.
    send_range(0, 9, 1, 0);
    tick(1, 30, rand16(), 0);
    chk("oor_err", int'(err_seq), 1);
    send_range(10, USED - 1, 0, 0);
    idle(2);
    chk("oor_even_outs", out_cnt, USED);
    out_cnt = 0;
    send_range(0, USED - 1, 0, 0);
    idle(2);
    chk("oor_odd_outs", out_cnt, USED);

    // Bare sync, then mid-frame resync during an odd frame.
    tick(0, 0, 0, 1);
    idle(3);
    send_range(0, USED - 1, 1, 0);
    send_range(0, 11, 0, 0);
    idle(2);
    out_cnt  = 0;
    sync_cnt = 0;
    send_range(0, USED - 1, 1, 0);
    idle(2);
    chk("resync_outs", out_cnt, 0);
    send_range(0, USED - 1, 0, 1);
    idle(2);
    chk("resync_odd_outs", out_cnt, USED);
    chk("resync_syncs", sync_cnt, 1);

    // Async reset in the middle of an odd frame.
    send_range(0, USED - 1, 1, 0);
    send_range(0, 9, 0, 0);
    async_reset();
    out_cnt = 0;
    send_range(0, USED - 1, 1, 0);
    idle(2);
    chk("rst_even_outs", out_cnt, 0);
    send_range(0, USED - 1, 0, 1);
    idle(2);
    chk("rst_odd_outs", out_cnt, USED);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
